sprite_printer: RTL and testbench

- Sprite-blit engine for the tank game's video path.
- Pops draw-command packets from a command FIFO that presents the head word while not empty.
- Fetches packed 16-bit pixels over an AHB-Lite read-only master port.
- Pushes a 17-bit header+pixel stream into a downstream pixel FIFO.
- Sits between the CPU command FIFO and the framebuffer writer.

---
 rtl/sprite_printer_pkg.sv | 22 ++
 rtl/sprite_printer_ahb_rd.sv | 54 +++++
 rtl/sprite_printer.sv | 154 +++++++++++++++
 tb/tb_sprite_printer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_printer_pkg.sv
// rtl/sprite_printer_pkg.sv - shared encodings and FSM states for the sprite blitter
package sprite_printer_pkg;

    localparam logic [1:0]  HTRANS_IDLE       = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ     = 2'b10;
    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int          HDR_BIT           = 16;

    typedef enum logic [3:0] {
        ST_SYNC,
        ST_SIZE,
        ST_BASE,
        ST_RSV,
        ST_HW,
        ST_HH,
        ST_ADDR,
        ST_DATA,
        ST_WLO,
        ST_WHI
    } state_e;

endpackage

// File: rtl/sprite_printer_ahb_rd.sv
// rtl/sprite_printer_ahb_rd.sv - single-outstanding AHB-Lite read engine
// req is held for the address phase; data_ack fires on the edge that completes the data phase.
module sprite_printer_ahb_rd
    import sprite_printer_pkg::*;
#(
    parameter int ADDR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] word_addr,
    output logic        addr_ack,
    output logic        data_ack,
    output logic [31:0] data,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    logic dphase_q, dphase_d;
    logic aphase;

    // A new address phase is only offered once the previous data phase has retired.
    assign aphase = req & ~dphase_q;

    always_comb begin
        dphase_d = dphase_q;
        addr_ack = 1'b0;
        data_ack = 1'b0;
        if (aphase && HREADY) begin
            addr_ack = 1'b1;
            dphase_d = 1'b1;
        end else if (dphase_q && HREADY) begin
            data_ack = 1'b1;
            dphase_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            dphase_q <= 1'b0;
        end else begin
            dphase_q <= dphase_d;
        end
    end

    assign HTRANS = aphase ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR  = aphase ? (word_addr << ADDR_SHIFT) : 32'h0;
    assign HWRITE = 1'b0;
    assign data   = HRDATA;

endmodule

// File: rtl/sprite_printer.sv
// rtl/sprite_printer.sv - sprite blit engine: command packets in, header+pixel stream out
// rst_n is an active-high synchronous reset despite its name.
module sprite_printer
    import sprite_printer_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEFAULT,
    parameter int          ADDR_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rempty,
    input  logic [31:0] rdata,
    output logic        rinc,
    input  logic        wfull,
    output logic        winc,
    output logic [16:0] wdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HRDATA
);

    state_e      state_q, state_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pair_q, pair_d;

    logic        ahb_req;
    logic        addr_ack;
    logic        data_ack;
    logic [31:0] ahb_data;

    assign ahb_req = (state_q == ST_ADDR);

    sprite_printer_ahb_rd #(
        .ADDR_SHIFT (ADDR_SHIFT)
    ) u_ahb_rd (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (ahb_req),
        .word_addr (addr_q),
        .addr_ack  (addr_ack),
        .data_ack  (data_ack),
        .data      (ahb_data),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA)
    );

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        addr_d   = addr_q;
        count_d  = count_q;
        pair_d   = pair_q;
        rinc     = 1'b0;
        winc     = 1'b0;
        wdata    = 17'h0;
        case (state_q)
            ST_SYNC: begin
                rinc = ~rempty;
                if (!rempty && rdata == SYNC_WORD) state_d = ST_SIZE;
            end
            ST_SIZE: begin
                rinc = ~rempty;
                if (!rempty) begin
                    width_d  = rdata[15:0];
                    height_d = rdata[31:16];
                    state_d  = ST_BASE;
                end
            end
            ST_BASE: begin
                rinc = ~rempty;
                if (!rempty) begin
                    addr_d  = rdata;
                    state_d = ST_RSV;
                end
            end
            ST_RSV: begin
                rinc = ~rempty;
                if (!rempty) begin
                    count_d = 32'(width_q) * 32'(height_q);
                    state_d = ST_HW;
                end
            end
            ST_HW: begin
                winc           = ~wfull;
                wdata[HDR_BIT] = 1'b1;
                wdata[15:0]    = width_q;
                if (!wfull) state_d = ST_HH;
            end
            ST_HH: begin
                winc           = ~wfull;
                wdata[HDR_BIT] = 1'b1;
                wdata[15:0]    = height_q;
                if (!wfull) state_d = (count_q != 32'h0) ? ST_ADDR : ST_SYNC;
            end
            ST_ADDR: begin
                if (addr_ack) begin
                    addr_d  = addr_q + 32'h1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_ack) begin
                    pair_d  = ahb_data;
                    state_d = ST_WLO;
                end
            end
            ST_WLO: begin
                winc        = ~wfull;
                wdata[15:0] = pair_q[15:0];
                if (!wfull) begin
                    count_d = count_q - 32'h1;
                    state_d = (count_q == 32'h1) ? ST_SYNC : ST_WHI;
                end
            end
            ST_WHI: begin
                winc        = ~wfull;
                wdata[15:0] = pair_q[31:16];
                if (!wfull) begin
                    count_d = count_q - 32'h1;
                    state_d = (count_q == 32'h1) ? ST_SYNC : ST_ADDR;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= ST_SYNC;
            width_q  <= 16'h0;
            height_q <= 16'h0;
            addr_q   <= 32'h0;
            count_q  <= 32'h0;
            pair_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            pair_q   <= pair_d;
        end
    end

endmodule

// File: tb/tb_sprite_printer.sv
// tb/tb_sprite_printer.sv - scoreboard bench for sprite_printer with FIFO and AHB slave models
module tb_sprite_printer;
    import sprite_printer_pkg::*;

    localparam int SHIFT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rempty = 1'b1;
    logic [31:0] rdata = 32'h0;
    logic        rinc;
    logic        wfull = 1'b0;
    logic        winc;
    logic [16:0] wdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = 32'h0;

    sprite_printer dut (
        .clk    (clk),
        .rst_n  (rst),
        .rempty (rempty),
        .rdata  (rdata),
        .rinc   (rinc),
        .wfull  (wfull),
        .winc   (winc),
        .wdata  (wdata),
        .HADDR  (HADDR),
        .HTRANS (HTRANS),
        .HWRITE (HWRITE),
        .HREADY (HREADY),
        .HRDATA (HRDATA)
    );

    always #5 clk = ~clk;

    logic [31:0] cmd_q[$];
    logic [16:0] exp_q[$];
    logic [31:0] exp_word[$];

    int total = 0;
    int bad = 0;
    int push_cnt = 0;
    int xfer_cnt = 0;
    int wfull_mode = 0;
    int hready_mode = 0;
    int wcnt = 0;
    bit pattern_mode = 1'b1;

    bit          will_pop = 1'b0;
    bit          stall_chk = 1'b0;
    logic [16:0] stall_val;
    bit          pending = 1'b0;
    bit          ahb_stalled = 1'b0;
    logic [31:0] pend_word;
    logic [31:0] stall_addr;
    logic        hr;
    logic [16:0] exp_push;
    logic [31:0] exp_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [15:0] h;
        if (pattern_mode) begin
            h = {a[3:0], 4'h6, a[3:0], 4'h1};
            return {h, h};
        end
        return ((a * 32'h9E37_79B1) ^ 32'h1357_2468) | 32'h0001_0001;
    endfunction

    // Reference model: a packet expands into two headers, w*h pixels and ceil(w*h/2) reads.
    task automatic send_packet(input logic [15:0] w, input logic [15:0] h,
                               input logic [31:0] base, input int ngarb);
        logic [31:0] n;
        logic [31:0] word;
        logic [31:0] d;
        for (int g = 0; g < ngarb; g++) begin
            word = $urandom;
            if (word == 32'hFFFF_FFFF) word = 32'h0;
            cmd_q.push_back(word);
        end
        cmd_q.push_back(32'hFFFF_FFFF);
        cmd_q.push_back({h, w});
        cmd_q.push_back(base);
        cmd_q.push_back($urandom);
        exp_q.push_back({1'b1, w});
        exp_q.push_back({1'b1, h});
        n = 32'(w) * 32'(h);
        for (int i = 0; i < int'(n); i++) begin
            word = base + 32'(i / 2);
            d = mem_word(word);
            exp_q.push_back((i % 2 == 1) ? {1'b0, d[31:16]} : {1'b0, d[15:0]});
        end
        for (int j = 0; j < int'((n + 1) / 2); j++) exp_word.push_back(base + 32'(j));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int c = 0;
        while ((exp_q.size() != 0 || exp_word.size() != 0 || cmd_q.size() != 0) && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (c >= budget) begin
            bad++;
            $display("FAIL %s_drain: left pushes=%0d reads=%0d words=%0d", tag,
                     exp_q.size(), exp_word.size(), cmd_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rinc"}, 32'(rinc), 32'h0);
        chk({tag, "_winc"}, 32'(winc), 32'h0);
        chk({tag, "_wdata"}, 32'(wdata), 32'h0);
        chk({tag, "_haddr"}, HADDR, 32'h0);
        chk({tag, "_htrans"}, 32'(HTRANS), 32'(HTRANS_IDLE));
        chk({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
    endtask

    // Command FIFO model: head word presented while not empty, popped on rinc edges.
    always @(negedge clk) begin
        will_pop = rinc && !rst;
        if (rinc && !rst) chk("rinc_while_empty", 32'(rempty), 32'h0);
    end

    always @(posedge clk) begin
        if (will_pop && cmd_q.size() > 0) void'(cmd_q.pop_front());
        will_pop = 1'b0;
        #1;
        rempty = (cmd_q.size() == 0);
        rdata  = rempty ? 32'h0 : cmd_q[0];
    end

    always @(posedge clk) begin
        #1;
        case (wfull_mode)
            1:       wfull = ~wfull;
            2:       wfull = ($urandom_range(0, 2) == 0);
            default: wfull = 1'b0;
        endcase
    end

    // Pixel FIFO monitor: pops the scoreboard on every push.
    always @(negedge clk) begin
        if (rst) begin
            stall_chk = 1'b0;
        end else begin
            if (stall_chk) chk("wdata_hold", 32'(wdata), 32'(stall_val));
            stall_chk = 1'b0;
            if (wfull && exp_q.size() > 0 && wdata == exp_q[0]) begin
                stall_chk = 1'b1;
                stall_val = wdata;
            end
            if (winc) begin
                chk("winc_while_full", 32'(wfull), 32'h0);
                push_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_push: got %h expected none", wdata);
                end else begin
                    exp_push = exp_q.pop_front();
                    chk("push_data", 32'(wdata), 32'(exp_push));
                end
            end
        end
    end

    // AHB slave: chooses HREADY for the coming edge, returns data only on the completing edge.
    always @(negedge clk) begin
        case (hready_mode)
            1: begin
                wcnt = (wcnt + 1) % 4;
                hr = (wcnt == 0);
            end
            2:       hr = ($urandom_range(0, 1) == 1);
            default: hr = 1'b1;
        endcase
        if (rst) begin
            pending     = 1'b0;
            ahb_stalled = 1'b0;
            HRDATA      = 32'h0;
        end else begin
            if (ahb_stalled) begin
                chk("htrans_hold", 32'(HTRANS), 32'(HTRANS_NONSEQ));
                chk("haddr_hold", HADDR, stall_addr);
            end
            ahb_stalled = 1'b0;
            HRDATA = 32'hDEAD_BEEF;
            if (pending && hr) begin
                HRDATA  = mem_word(pend_word);
                pending = 1'b0;
            end
            if (HTRANS == HTRANS_NONSEQ) begin
                chk("one_outstanding", 32'(pending), 32'h0);
                if (hr) begin
                    xfer_cnt++;
                    if (exp_word.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_transfer: got haddr %h expected none", HADDR);
                    end else begin
                        exp_w = exp_word.pop_front();
                        chk("haddr", HADDR, exp_w << SHIFT);
                        pend_word = exp_w;
                        pending   = 1'b1;
                    end
                end else begin
                    ahb_stalled = 1'b1;
                    stall_addr  = HADDR;
                end
            end
        end
        HREADY = hr;
    end

    initial begin
        int p0;
        int x0;
        int c;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");

        // Basic 15x15 packet at word 3 with the nibble pattern.
        p0 = push_cnt;
        x0 = xfer_cnt;
        send_packet(16'd15, 16'd15, 32'h3, 0);
        wait_done(5000, "basic");
        chk("basic_pushes", 32'(push_cnt - p0), 32'd227);
        chk("basic_xfers", 32'(xfer_cnt - x0), 32'd113);

        // Non-marker words ahead of the packet are discarded.
        cmd_q.push_back(32'h0000_1234);
        cmd_q.push_back(32'h0000_0000);
        p0 = push_cnt;
        send_packet(16'd15, 16'd15, 32'h3, 0);
        wait_done(5000, "garbage");
        chk("garbage_pushes", 32'(push_cnt - p0), 32'd227);

        pattern_mode = 1'b0;

        wfull_mode = 1;
        send_packet(16'd5, 16'd3, $urandom, 1);
        wait_done(5000, "backpressure");

        wfull_mode = 0;
        hready_mode = 1;
        send_packet(16'd4, 16'd3, $urandom, 0);
        wait_done(5000, "waitstates");

        // Zero height: headers only, no bus traffic.
        hready_mode = 0;
        x0 = xfer_cnt;
        p0 = push_cnt;
        send_packet(16'd3, 16'd0, 32'h0, 0);
        wait_done(2000, "zero");
        chk("zero_xfers", 32'(xfer_cnt - x0), 32'd0);
        chk("zero_pushes", 32'(push_cnt - p0), 32'd2);

        // Word address wraps past 0xFFFF_FFFF.
        hready_mode = 2;
        send_packet(16'd3, 16'd2, 32'hFFFF_FFFE, 0);
        wait_done(5000, "wrap");

        for (int k = 0; k < 6; k++) begin
            wfull_mode  = $urandom_range(0, 2);
            hready_mode = $urandom_range(0, 2);
            send_packet(16'($urandom_range(0, 7)), 16'($urandom_range(0, 7)), $urandom,
                        $urandom_range(0, 2));
            if (k % 2 == 1) wait_done(20000, "random");
        end

        // Reset in the middle of the pixel stream.
        wfull_mode  = 0;
        hready_mode = 0;
        p0 = push_cnt;
        send_packet(16'd8, 16'd8, $urandom, 0);
        c = 0;
        while (push_cnt < p0 + 20 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        total++;
        if (c >= 2000) begin
            bad++;
            $display("FAIL midreset_progress: got %0d pushes expected 20", push_cnt - p0);
        end
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_word.delete();
        check_reset_outputs("midreset");
        p0 = push_cnt;
        x0 = xfer_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("midreset_quiet_pushes", 32'(push_cnt - p0), 32'd0);
        chk("midreset_quiet_xfers", 32'(xfer_cnt - x0), 32'd0);
        p0 = push_cnt;
        send_packet(16'd2, 16'd3, $urandom, 0);
        wait_done(5000, "restart");
        chk("restart_pushes", 32'(push_cnt - p0), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
